alu_seq: RTL

//  Registered, handshaked successor of the combinational ALU. Generalised to WIDTH-bit operands.

---
 rtl/alu_seq_pkg.sv | 31 +++
 rtl/alu_seq_mul.sv | 46 ++++
 rtl/alu_seq.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - opcode and FSM state types for alu_seq (MUL_BUSY only with ALU_SEQ_MUL_EN)
package alu_seq_pkg;

   typedef enum logic [3:0] {
      OP_AND   = 4'd0,
      OP_OR    = 4'd1,
      OP_XOR   = 4'd2,
      OP_NOT   = 4'd3,
      OP_ADDU  = 4'd4,
      OP_ADDS  = 4'd5,
      OP_SUBU  = 4'd6,
      OP_SUBS  = 4'd7,
      OP_MULU  = 4'd8,
      OP_SHL   = 4'd9,
      OP_SHR   = 4'd10,
      OP_SRA   = 4'd11,
      OP_CMPU  = 4'd12,
      OP_CMPS  = 4'd13,
      OP_ILL14 = 4'd14,
      OP_ILL15 = 4'd15
   } op_e;

`ifdef ALU_SEQ_MUL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, MUL_BUSY = 2'd1, DONE = 2'd2} state_e;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_e;
`endif

   localparam logic [3:0] OP_ILLEGAL_MIN = 4'd14;

endpackage

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - radix-2 shift-add multiplier, WIDTH iterations between start and done
module alu_seq_mul #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] acc;
   logic [CW-1:0]      cnt;
   logic               busy;
   logic [WIDTH:0]     partial;

   // acc low half starts as the multiplier and is consumed LSB-first as the product shifts in
   assign partial = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
   assign product = {partial, acc[WIDTH-1:1]};
   assign done    = busy && (cnt == CW'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy  <= 1'b0;
         cnt   <= '0;
         acc   <= '0;
         mcand <= '0;
      end else if (start) begin
         busy  <= 1'b1;
         cnt   <= '0;
         acc   <= {{WIDTH{1'b0}}, b};
         mcand <= a;
      end else if (busy) begin
         acc <= product;
         cnt <= cnt + 1'b1;
         if (done) begin
            busy <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - registered handshaked ALU; MULU via alu_seq_mul when ALU_SEQ_MUL_EN is defined
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] result,
   output logic               overflow,
   output logic               error
);
   localparam int SW = $clog2(WIDTH);
   localparam int DW = 2 * WIDTH;

   state_e         state;
   op_e            op_sel;
   logic           accept;
   logic [SW-1:0]  sh;
   logic [WIDTH:0] sum_u;
   logic [WIDTH:0] dif_u;
   logic [DW-1:0]  alu_res;
   logic           alu_ovf;
   logic           alu_err;

   assign op_sel    = op_e'(op);
   assign sh        = b[SW-1:0];
   assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
   assign accept    = in_valid && in_ready;
   assign out_valid = (state == DONE);
   assign sum_u     = {1'b0, a} + {1'b0, b};
   assign dif_u     = {1'b0, a} - {1'b0, b};

   // MULU and the reserved codes fall to default; with the multiplier built, MULU never uses this path
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_err = 1'b0;
      case (op_sel)
         OP_AND:  alu_res = {{WIDTH{1'b0}}, a & b};
         OP_OR:   alu_res = {{WIDTH{1'b0}}, a | b};
         OP_XOR:  alu_res = {{WIDTH{1'b0}}, a ^ b};
         OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a};
         OP_ADDU: begin
            alu_res = {{(WIDTH-1){1'b0}}, sum_u};
            alu_ovf = sum_u[WIDTH];
         end
         OP_ADDS: begin
            alu_res = {{WIDTH{sum_u[WIDTH-1]}}, sum_u[WIDTH-1:0]};
            alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_u[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SUBU: begin
            alu_res = {{WIDTH{1'b0}}, dif_u[WIDTH-1:0]};
            alu_ovf = dif_u[WIDTH];
         end
         OP_SUBS: begin
            alu_res = {{WIDTH{dif_u[WIDTH-1]}}, dif_u[WIDTH-1:0]};
            alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif_u[WIDTH-1] != a[WIDTH-1]);
         end
         OP_SHL:  alu_res = {{WIDTH{1'b0}}, a} << sh;
         OP_SHR:  alu_res = {{WIDTH{1'b0}}, a >> sh};
         OP_SRA:  alu_res = $signed({{WIDTH{a[WIDTH-1]}}, a}) >>> sh;
         OP_CMPU: alu_res = {{(DW-3){1'b0}}, a > b, a == b, a < b};
         OP_CMPS: alu_res = {{(DW-3){1'b0}}, $signed(a) > $signed(b), a == b,
                             $signed(a) < $signed(b)};
         default: alu_err = 1'b1;
      endcase
   end

`ifdef ALU_SEQ_MUL_EN
   logic          mul_done;
   logic [DW-1:0] mul_product;

   alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (accept && (op_sel == OP_MULU)),
      .a       (a),
      .b       (b),
      .done    (mul_done),
      .product (mul_product)
   );
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         result   <= '0;
         overflow <= 1'b0;
         error    <= 1'b0;
      end else if (accept) begin
`ifdef ALU_SEQ_MUL_EN
         if (op_sel == OP_MULU) begin
            state <= MUL_BUSY;
         end else
`endif
         begin
            state    <= DONE;
            result   <= alu_res;
            overflow <= alu_ovf;
            error    <= alu_err;
         end
      end
`ifdef ALU_SEQ_MUL_EN
      else if (state == MUL_BUSY) begin
         if (mul_done) begin
            state    <= DONE;
            result   <= mul_product;
            overflow <= 1'b0;
            error    <= 1'b0;
         end
      end
`endif
      else if ((state == DONE) && out_ready) begin
         state <= IDLE;
      end
   end

endmodule
